color_shuffler: RTL and testbench
=================================

COLOR_SHUFFLER -- requirements
Module: color_shuffler

Interface
REQ-001 Parameter LFSR_SEED, 16'hACE1, LFSR reset value; SHALL be nonzero.
REQ-002 Parameter RETRY_MAX, 8, maximum rejected index draws per shuffle step before the fallback applies.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 compute_colors  input  1  level request from the game state machine; a 0->1 transition starts a shuffle.
REQ-006 computing_colors_finished  output  1  one-cycle pulse when the shuffle completes.
REQ-007 card_colors  output  48  16 cards x 3-bit color; card k occupies bits [3k+2:3k].
REQ-008 card_colors_valid  output  1  high while card_colors holds a completed shuffle.
REQ-009 busy  output  1  high from the start cycle through the DONE cycle inclusive.

Function
REQ-010 The LFSR SHALL be a 16-bit Fibonacci LFSR, shift left, new bit0 = b15^b13^b12^b10, advancing every clock in every state, including IDLE.
REQ-011 Random index r SHALL be LFSR bits [3:0], sampled in the current cycle.
REQ-012 The start condition SHALL be compute_colors==1 while its registered copy from the previous cycle is 0, evaluated only in IDLE; a level held high SHALL NOT restart.
REQ-013 States SHALL be IDLE, FILL, PICK, SWAP, DONE.
REQ-014 IDLE -> FILL on the start condition; the same edge SHALL clear card_colors_valid and set busy.
REQ-015 FILL, 1 cycle: slot k <= k>>1 for all k in parallel (colors 0..7, two each); step index i <= 15; retry count <= 0; -> PICK.
REQ-016 PICK: if r <= i, latch j <= r and go to SWAP; else, if retry count == RETRY_MAX-1, latch j <= i (no-op swap) and go to SWAP; otherwise increment retry count and stay in PICK.
REQ-017 SWAP, 1 cycle: exchange slot i and slot j (j==i leaves the contents unchanged); retry count <= 0; if i==1 -> DONE, else i <= i-1 and -> PICK.
REQ-018 DONE, 1 cycle: computing_colors_finished=1; card_colors_valid <= 1; -> IDLE; busy low from the next cycle.
REQ-019 Latency from the start-detect edge to the finished pulse SHALL be 2 + 15x(p+1) cycles, where p is the number of PICK cycles per step (1..RETRY_MAX); the bound is 137 cycles for RETRY_MAX=8.
REQ-020 The final card_colors SHALL always contain each color 0..7 exactly twice, regardless of the random values drawn.
REQ-021 card_colors SHALL change only in FILL and SWAP; between shuffles it SHALL hold its value.
REQ-022 A compute_colors toggle while busy SHALL be ignored; the edge-detect register still tracks the input.
REQ-023 compute_colors remaining high for 1+ cycles after the finished pulse SHALL NOT produce a second shuffle or pulse.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 While rst is high: state=IDLE, LFSR=LFSR_SEED, card_colors=0, card_colors_valid=0, busy=0, computing_colors_finished=0, edge-detect register=0, i=0, j=0, retry count=0.
REQ-026 Reset asserted mid-shuffle SHALL abort immediately; there SHALL be no finished pulse. After release, compute_colors already high SHALL count as a rising edge on the first clock.

Verification
REQ-027 Assert rst, release, hold compute_colors=0 for 20 cycles -> all outputs 0; LFSR sequence from 16'hACE1 matches the reference model.
REQ-028 Raise compute_colors 5 cycles after reset and hold it high -> exactly one finished pulse within 137 cycles; card_colors matches a cycle-accurate model; each color 0..7 appears twice; valid=1.
REQ-029 Run 200 back-to-back requests (compute_colors low 1-50 random cycles, then high until the pulse) -> every result is a valid pair multiset; the pulse count equals the request count.
REQ-030 Force the LFSR low nibble to 4'hF during step i=3 -> exactly RETRY_MAX PICK cycles, then a no-op swap with slot 3 unchanged.
REQ-031 Assert rst at cycle 40 of a shuffle -> no pulse; outputs return to the REQ-025 values asynchronously; the next request completes normally.
REQ-032 Pulse compute_colors 0->1->0->1 while busy -> still one shuffle and one pulse; result unaffected.

Source files
------------

// File: rtl/color_shuffler.sv
// Color shuffler: deals 16 cards (8 colors, two of each) into a random order
// with an LFSR-driven Fisher-Yates shuffle. Index draws larger than the
// current step index are rejected and redrawn; after RETRY_MAX rejections the
// step degenerates to a no-op swap so the latency stays bounded.
module color_shuffler #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned RETRY_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        compute_colors,
  output logic        computing_colors_finished,
  output logic [47:0] card_colors,
  output logic        card_colors_valid,
  output logic        busy
);

  localparam int unsigned RW = (RETRY_MAX > 1) ? $clog2(RETRY_MAX) : 1;
  localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX - 1);

  typedef enum logic [2:0] {IDLE, FILL, PICK, SWAP, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [15:0]   lfsr;
  logic [3:0]    r;
  logic [3:0]    i;
  logic [3:0]    j;
  logic [RW-1:0] retry;
  logic          comp_q;
  logic          start;
  logic          pick_ok;
  logic          pick_last;

  assign r         = lfsr[3:0];
  assign start     = compute_colors & ~comp_q;
  assign pick_ok   = (r <= i);
  assign pick_last = (retry == RETRY_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = FILL;
      FILL: state_next = PICK;
      PICK: if (pick_ok || pick_last) state_next = SWAP;
      SWAP: state_next = (i == 4'd1) ? DONE : PICK;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Free-running LFSR and request edge-detect register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr   <= LFSR_SEED;
      comp_q <= 1'b0;
    end else begin
      lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      comp_q <= compute_colors;
    end
  end

  // Shuffle datapath and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      card_colors               <= '0;
      card_colors_valid         <= 1'b0;
      busy                      <= 1'b0;
      computing_colors_finished <= 1'b0;
      i                         <= '0;
      j                         <= '0;
      retry                     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            card_colors_valid <= 1'b0;
            busy              <= 1'b1;
          end
        end
        FILL: begin
          for (int unsigned k = 0; k < 16; k++)
            card_colors[3*k +: 3] <= 3'(k >> 1);
          i     <= 4'd15;
          retry <= '0;
        end
        PICK: begin
          if (pick_ok)        j <= r;
          else if (pick_last) j <= i;
          else                retry <= retry + 1'b1;
        end
        SWAP: begin
          // Both writes read the pre-swap contents, so j == i is a no-op.
          card_colors[3*int'(i) +: 3] <= card_colors[3*int'(j) +: 3];
          card_colors[3*int'(j) +: 3] <= card_colors[3*int'(i) +: 3];
          retry <= '0;
          // Finished is raised on entry to DONE so it is high exactly in DONE.
          if (i == 4'd1) computing_colors_finished <= 1'b1;
          else           i <= i - 1'b1;
        end
        DONE: begin
          computing_colors_finished <= 1'b0;
          card_colors_valid         <= 1'b1;
          busy                      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_color_shuffler.sv
// Self-checking bench for color_shuffler: a sequence-level shuffle model fed
// by a reference LFSR stream predicts latency and final card order.
module tb_color_shuffler;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int RM = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        compute_colors;
  logic        computing_colors_finished;
  logic [47:0] card_colors;
  logic        card_colors_valid;
  logic        busy;

  int          tests = 0;
  int          fails = 0;
  int          pulses = 0;
  int          requests = 0;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  color_shuffler #(.LFSR_SEED(SEED), .RETRY_MAX(RM)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .compute_colors            (compute_colors),
    .computing_colors_finished (computing_colors_finished),
    .card_colors               (card_colors),
    .card_colors_valid         (card_colors_valid),
    .busy                      (busy)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] nxt(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Fisher-Yates over the LFSR stream; l0 is the LFSR value in the cycle the
  // request is detected. Each clock edge consumes one LFSR step.
  function automatic void model(input logic [15:0] l0, output logic [47:0] cols,
                                output int lat, output bit fb3, output logic [2:0] s3);
    logic [2:0]  s [16];
    logic [2:0]  t;
    logic [15:0] l;
    int          p;
    int          jj;
    fb3 = 1'b0;
    s3  = '0;
    for (int k = 0; k < 16; k++) s[k] = 3'(k / 2);
    l   = nxt(l0);
    lat = 1;
    for (int ii = 15; ii >= 1; ii--) begin
      l = nxt(l); lat++;
      p = 1;
      while (1) begin
        if (int'(l[3:0]) <= ii) begin jj = int'(l[3:0]); break; end
        if (p == RM) begin jj = ii; if (ii == 3) fb3 = 1'b1; break; end
        l = nxt(l); lat++; p++;
      end
      l = nxt(l); lat++;
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
      if (ii == 3) s3 = s[3];
    end
    lat++;
    cols = '0;
    for (int k = 0; k < 16; k++) cols[3*k +: 3] = s[k];
  endfunction

  function automatic bit pairs_ok(input logic [47:0] c);
    int cnt [8];
    for (int k = 0; k < 8; k++) cnt[k] = 0;
    for (int k = 0; k < 16; k++) cnt[int'(c[3*k +: 3])]++;
    for (int k = 0; k < 8; k++) if (cnt[k] != 2) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) m_lfsr = SEED;
    else     m_lfsr = nxt(m_lfsr);
    @(negedge clk);
    if (computing_colors_finished) pulses++;
  endtask

  task automatic run_shuffle(input bit toggle, input bit watch3);
    logic [47:0] ec;
    int          lat;
    bit          fb3;
    logic [2:0]  s3;
    bit          seen;
    int          c3;
    bit          got2;
    model(m_lfsr, ec, lat, fb3, s3);
    compute_colors = 1'b1;
    requests++;
    seen = 1'b0;
    c3   = 0;
    got2 = 1'b0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      step();
      if (toggle) begin
        if (k == 10 || k == 12) compute_colors = 1'b0;
        if (k == 11 || k == 13) compute_colors = 1'b1;
      end
      if (watch3) begin
        if (dut.i == 4'd3) c3++;
        if (dut.i == 4'd2 && !got2) begin
          got2 = 1'b1;
          chk("slot3_after_step3", 64'(card_colors[11:9]), 64'(s3));
        end
      end
      if (computing_colors_finished) begin
        seen = 1'b1;
        chk("latency", 64'(k), 64'(lat));
        chk("latency_bound", 64'(k <= 137), 64'd1);
        chk("cards_at_done", 64'(card_colors), 64'(ec));
        chk("busy_at_done", 64'(busy), 64'd1);
        chk("valid_at_done", 64'(card_colors_valid), 64'd0);
      end else begin
        chk("busy_during", 64'(busy), 64'd1);
        chk("valid_during", 64'(card_colors_valid), 64'd0);
      end
    end
    if (!seen) chk("finish_timeout", 64'd0, 64'd1);
    if (watch3) begin
      chk("fallback_step3", 64'(fb3), 64'd1);
      chk("step3_cycles", 64'(c3), 64'(RM + 1));
    end
    step();
    chk("valid_after", 64'(card_colors_valid), 64'd1);
    chk("busy_after", 64'(busy), 64'd0);
    chk("finished_after", 64'(computing_colors_finished), 64'd0);
    chk("cards_after", 64'(card_colors), 64'(ec));
    chk("pairs", 64'(pairs_ok(card_colors)), 64'd1);
  endtask

  initial begin
    logic [47:0] tc;
    logic [15:0] tmp;
    int          tl;
    bit          tf;
    logic [2:0]  ts;
    int          dd;

    rst            = 1'b1;
    compute_colors = 1'b0;
    m_lfsr         = SEED;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({card_colors, card_colors_valid, busy, computing_colors_finished}), 64'd0);
    chk("reset_lfsr", 64'(dut.lfsr), 64'(SEED));
    rst = 1'b0;

    // Idle after reset: outputs stay zero, LFSR follows the reference stream.
    for (int n = 0; n < 20; n++) begin
      step();
      chk("idle_outputs", 64'({card_colors, card_colors_valid, busy, computing_colors_finished}), 64'd0);
      chk("idle_lfsr", 64'(dut.lfsr), 64'(m_lfsr));
    end

    // First shuffle, then request held high must not restart.
    run_shuffle(1'b0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      step();
      chk("held_no_restart_busy", 64'(busy), 64'd0);
      chk("held_no_restart_fin", 64'(computing_colors_finished), 64'd0);
    end
    compute_colors = 1'b0;
    repeat (3) step();

    // Request toggled while busy.
    run_shuffle(1'b1, 1'b0);
    compute_colors = 1'b0;
    step();

    // Find a start time whose draw stream exhausts the retries at step 3.
    tmp = m_lfsr;
    dd  = 0;
    for (int d = 1; d <= 1000 && dd == 0; d++) begin
      tmp = nxt(tmp);
      model(tmp, tc, tl, tf, ts);
      if (tf) dd = d;
    end
    chk("fallback_search", 64'(dd != 0), 64'd1);
    if (dd != 0) begin
      repeat (dd) step();
      run_shuffle(1'b0, 1'b1);
      compute_colors = 1'b0;
      step();
    end

    // Abort mid-shuffle with an asynchronous reset; request stays high.
    compute_colors = 1'b1;
    repeat (40) step();
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", 64'({card_colors, card_colors_valid, busy, computing_colors_finished}), 64'd0);
    chk("async_reset_lfsr", 64'(dut.lfsr), 64'(SEED));
    m_lfsr = SEED;
    repeat (3) begin
      step();
      chk("in_reset_fin", 64'(computing_colors_finished), 64'd0);
    end
    rst = 1'b0;
    run_shuffle(1'b0, 1'b0);

    // Back-to-back randomized requests.
    for (int n = 0; n < 200; n++) begin
      compute_colors = 1'b0;
      repeat ($urandom_range(1, 50)) step();
      run_shuffle(1'b0, 1'b0);
    end
    compute_colors = 1'b0;
    repeat (3) step();

    chk("pulse_count", 64'(pulses), 64'(requests));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
